// File: rtl/uart_pkg.sv
// Shared encodings for the UART receiver: parity modes, FSM states and
// the parity-check helper used when the parity bit is sampled.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Mode 2'b11 falls through to "no parity bit on the wire".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

  // XOR of data and parity bit is 1 for an odd count of ones.
  function automatic logic parity_mismatch(input logic [1:0] mode,
                                           input logic [7:0] data,
                                           input logic       pbit);
    return (^data ^ pbit) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver and the agent that drives its line
// and consumes received bytes.
interface uart_rx_if;
  // Handshake: a byte is transferred on every clock edge where valid=1 and
  // ready=1; valid stays high with data/flags stable until that edge, except
  // that a newer frame may overwrite an unconsumed byte (flagged by overrun).
  logic [1:0] parity;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  modport master (
    output parity, rx, ready,
    input  data, valid, parity_err, frame_err, overrun
  );

  modport slave (
    input  parity, rx, ready,
    output data, valid, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high line level so a reset never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits LSB first, optional odd/even
// parity, one stop bit, with a registered valid/ready output stage.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic        baud_clk,
  input  logic        rst_n,
  input  logic [1:0]  parity_i,
  input  logic        rx_i,
  input  logic        ready_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output uart_state_e state_o
);

  localparam int              CW       = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(OVERSAMPLE / 2 - 1);

  logic        rx_s;

  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [1:0]  mode_q, mode_d;
  logic        perr_q, perr_d;

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        par_err_q, par_err_d;
  logic        frm_err_q, frm_err_d;
  logic        ovr_q, ovr_d;

  logic        tick;
  logic        done;

  uart_sync2 u_sync (
    .clk   (baud_clk),
    .rst_n (rst_n),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  assign tick = (cnt_q == CNT_LAST);

  // Counter free-runs modulo OVERSAMPLE from the mid-start sample, so every
  // later sample lands on the same phase of its bit with no accumulated drift.
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    mode_d  = mode_q;
    perr_d  = perr_q;
    done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          mode_d  = parity_i;
          perr_d  = 1'b0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = parity_enabled(mode_q) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          perr_d  = parity_mismatch(mode_q, shreg_q, rx_s);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          done    = 1'b1;
          state_d = rx_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A completing frame always loads; it is an overrun only if the previous
  // byte is still unconsumed and not being accepted on this very edge.
  always_comb begin
    data_d    = data_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    valid_d   = valid_q & ~ready_i;
    ovr_d     = ovr_q;
    if (done) begin
      data_d    = shreg_q;
      par_err_d = perr_q;
      frm_err_d = ~rx_s;
      valid_d   = 1'b1;
      ovr_d     = ovr_q | (valid_q & ~ready_i);
    end
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      mode_q    <= PAR_NONE;
      perr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      mode_q    <= mode_d;
      perr_q    <= perr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = par_err_q;
  assign frame_err_o  = frm_err_q;
  assign overrun_o    = ovr_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit on the negative
// edge, expected bytes/flags are queued at drive time and popped on output.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS   = 16;
  localparam int HALF = OS / 2;

  logic        clk = 1'b0;
  logic        rst_n;
  uart_state_e dbg_state;
  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_q[$];

  uart_rx_if bus ();

  always #5 clk = ~clk;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .baud_clk     (clk),
    .rst_n        (rst_n),
    .parity_i     (bus.parity),
    .rx_i         (bus.rx),
    .ready_i      (bus.ready),
    .data_o       (bus.data),
    .valid_o      (bus.valid),
    .parity_err_o (bus.parity_err),
    .frame_err_o  (bus.frame_err),
    .overrun_o    (bus.overrun),
    .state_o      (dbg_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_perr(input logic [1:0] mode, input logic [7:0] d, input logic pb);
    int ones;
    ones = $countones(d) + int'(pb);
    if (mode == 2'b01) return (ones % 2) == 0;
    if (mode == 2'b10) return (ones % 2) == 1;
    return 1'b0;
  endfunction

  // Called on a negative edge; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode,
                            input logic pb, input logic stop);
    exp_q.push_back({~stop, model_perr(mode, d, pb), d});
    bus.parity = mode;
    bus.rx     = 1'b0;
    repeat (OS) @(negedge clk);
    bus.parity = (mode == 2'b00) ? 2'b10 : ~mode;
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (OS) @(negedge clk);
    end
    if (mode == 2'b01 || mode == 2'b10) begin
      bus.rx = pb;
      repeat (OS) @(negedge clk);
    end
    bus.rx = stop;
    repeat (OS) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (bus.valid) break;
    end
  endtask

  task automatic check_output(input string tag);
    logic [9:0] e;
    check({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
    check({tag, "_valid"}, 32'(bus.valid), 32'd1);
    check({tag, "_data"}, 32'(bus.data), 32'(e[7:0]));
    check({tag, "_perr"}, 32'(bus.parity_err), 32'(e[8]));
    check({tag, "_ferr"}, 32'(bus.frame_err), 32'(e[9]));
  endtask

  task automatic consume(input string tag);
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    check(tag, 32'(bus.valid), 32'd0);
  endtask

  initial begin
    int   n;
    logic saw;

    rst_n      = 1'b0;
    bus.rx     = 1'b1;
    bus.ready  = 1'b0;
    bus.parity = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_data", 32'(bus.data), 32'h00);
    check("rst_perr", 32'(bus.parity_err), 32'd0);
    check("rst_ferr", 32'(bus.frame_err), 32'd0);
    check("rst_ovr", 32'(bus.overrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // No parity: valid rises on the edge after the stop sample.
    fork
      send_frame(8'hAA, 2'b00, 1'b0, 1'b1);
      wait_valid(400, n);
    join
    check("lat_none", n, 3 + HALF + 9 * OS);
    check_output("aa");
    check("aa_ovr", 32'(bus.overrun), 32'd0);
    consume("aa_ack");
    repeat (OS) @(negedge clk);

    // Even parity, correct then wrong parity bit.
    fork
      send_frame(8'h55, 2'b10, 1'b0, 1'b1);
      wait_valid(400, n);
    join
    check("lat_par", n, 3 + HALF + 10 * OS);
    check_output("e55");
    consume("e55_ack");
    fork
      send_frame(8'h55, 2'b10, 1'b1, 1'b1);
      wait_valid(400, n);
    join
    check_output("e55_bad");
    consume("e55_bad_ack");

    // Odd parity, then a low stop bit leading into a held break.
    fork
      send_frame(8'h00, 2'b01, 1'b1, 1'b1);
      wait_valid(400, n);
    join
    check_output("o00");
    consume("o00_ack");
    fork
      send_frame(8'h00, 2'b01, 1'b1, 1'b0);
      wait_valid(400, n);
    join
    check_output("o00_stop");
    consume("o00_stop_ack");
    repeat (3 * OS) @(negedge clk);
    check("brk_state", 32'(dbg_state), 32'(ST_BREAK));
    check("brk_quiet", 32'(bus.valid), 32'd0);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    check("brk_exit", 32'(dbg_state), 32'(ST_IDLE));
    repeat (OS) @(negedge clk);

    // Glitch shorter than half a bit.
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    check("glitch_start", 32'(dbg_state), 32'(ST_START));
    saw = 1'b0;
    repeat (3 * OS) begin
      @(negedge clk);
      saw |= bus.valid;
    end
    check("glitch_valid", 32'(saw), 32'd0);
    check("glitch_state", 32'(dbg_state), 32'(ST_IDLE));

    // Overrun: second frame lands on an unconsumed byte.
    fork
      send_frame(8'h11, 2'b00, 1'b0, 1'b1);
      wait_valid(400, n);
    join
    check_output("ov1");
    check("ov1_ovr", 32'(bus.overrun), 32'd0);
    send_frame(8'h22, 2'b00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check_output("ov2");
    check("ov2_ovr", 32'(bus.overrun), 32'd1);
    consume("ov_ack");
    check("ov_sticky", 32'(bus.overrun), 32'd1);
    repeat (OS) @(negedge clk);

    // Reset in the middle of data bit 3; line left idle afterwards.
    bus.rx = 1'b0;
    repeat (OS) @(negedge clk);
    bus.rx = 1'b1;
    repeat (OS) @(negedge clk);
    bus.rx = 1'b1;
    repeat (OS) @(negedge clk);
    bus.rx = 1'b0;
    repeat (OS) @(negedge clk);
    bus.rx = 1'b1;
    repeat (HALF) @(negedge clk);
    check("mid_state", 32'(dbg_state), 32'(ST_DATA));
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(bus.valid), 32'd0);
    check("mr_data", 32'(bus.data), 32'h00);
    check("mr_perr", 32'(bus.parity_err), 32'd0);
    check("mr_ferr", 32'(bus.frame_err), 32'd0);
    check("mr_ovr", 32'(bus.overrun), 32'd0);
    check("mr_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (3 * OS) begin
      @(negedge clk);
      saw |= bus.valid;
    end
    check("mr_quiet", 32'(saw), 32'd0);
    fork
      send_frame(8'hC3, 2'b00, 1'b0, 1'b1);
      wait_valid(400, n);
    join
    check("lat_c3", n, 3 + HALF + 9 * OS);
    check_output("c3");
    check("c3_ovr", 32'(bus.overrun), 32'd0);
    consume("c3_ack");

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: baud_clk cycles per bit; legal values are even and at least 8.
REQ-002 SHALL have port baud_clk, input, 1 bit: single clock, running at OVERSAMPLE times the bit rate.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port parity_i, input, 2 bits: 00 none, 01 odd, 10 even, 11 treated as none.
REQ-005 SHALL have port rx_i, input, 1 bit: serial line, asynchronous, idle high.
REQ-006 SHALL have port ready_i, input, 1 bit: consumer accepts data_o.
REQ-007 SHALL have port data_o, output, 8 bits: last received byte.
REQ-008 SHALL have port valid_o, output, 1 bit: data_o holds an unconsumed byte.
REQ-009 SHALL have port parity_err_o, output, 1 bit: parity mismatch on the byte in data_o.
REQ-010 SHALL have port frame_err_o, output, 1 bit: stop bit sampled low on the byte in data_o.
REQ-011 SHALL have port overrun_o, output, 1 bit: sticky; set when a frame completes while valid_o=1.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer; all logic uses the synchronized value (rx_s).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, and BREAK.
REQ-014 IDLE: on rx_s=0, SHALL go to START and latch parity_i; later parity_i changes SHALL not affect the frame in progress.
REQ-015 START: SHALL sample rx_s at OVERSAMPLE/2 cycles after the falling edge; if 1, false start, return to IDLE with no output change; if 0, go to DATA.
REQ-016 DATA: SHALL take 8 samples, one every OVERSAMPLE cycles, LSB first; after bit 7, go to PARITY if parity is enabled, else STOP.
REQ-017 PARITY: SHALL take one sample; for odd parity the data bits plus parity bit SHALL have an odd count of ones; for even parity, an even count; a mismatch sets the pending parity error.
REQ-018 STOP: SHALL take one sample; if 0, set the pending frame error and go to BREAK; if 1, go to IDLE.
REQ-019 BREAK: SHALL wait until rx_s=1, then go to IDLE; a line held low SHALL produce no further frames.
REQ-020 On the cycle after the stop sample, data_o, parity_err_o, and frame_err_o SHALL update and valid_o SHALL rise; latency is exactly 1 cycle, with no framing-based suppression.
REQ-021 valid_o SHALL clear in the cycle after valid_o=1 and ready_i=1.
REQ-022 If a frame completes while valid_o=1 and ready_i=0: data_o and flags SHALL be overwritten, valid_o stays 1, and overrun_o is set.
REQ-023 If a frame completes in the same cycle a handshake occurs: the new byte SHALL load, valid_o stays 1, and there is no overrun.
REQ-024 overrun_o SHALL clear only on reset.
REQ-025 Sample counter width SHALL be $clog2(OVERSAMPLE); the counter SHALL wrap with no drift between bits.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, counters 0, synchronizer flops 1, data_o=0x00, and valid_o, parity_err_o, frame_err_o, overrun_o=0.
REQ-027 A reset asserted mid-frame SHALL discard the partial frame; reception resumes only on the next falling edge after rst_n=1.

Structure
REQ-028 SHALL use shared package uart_pkg, holding the parity encodings (PAR_NONE, PAR_ODD, PAR_EVEN) and the state encoding.
REQ-029 SHALL implement the synchronizer as sub-module uart_sync2.
REQ-030 RTL SHALL be 120-400 lines.

Verification
REQ-031 Bench SHALL cover: OVERSAMPLE=16, parity 00, frame 0xAA -> valid_o 1 cycle after stop sample, data_o=0xAA, all flags 0.
REQ-032 Bench SHALL cover: parity 10, frame 0x55 with parity bit 0 -> data_o=0x55, parity_err_o=0; same frame with parity bit 1 -> parity_err_o=1.
REQ-033 Bench SHALL cover: parity 01, frame 0x00 with parity bit 1 -> no error; stop bit driven 0 -> frame_err_o=1, FSM stays in BREAK until rx_i returns high.
REQ-034 Bench SHALL cover: rx_i low for 4 cycles only -> no valid_o, state back in IDLE.
REQ-035 Bench SHALL cover: ready_i=0, two frames 0x11 then 0x22 -> data_o=0x22, overrun_o=1; ready_i pulse -> valid_o=0.
REQ-036 Bench SHALL cover: rst_n pulsed low during DATA bit 3 -> all outputs at reset values, and the next full frame 0xC3 is received correctly.
